pipe_mmio_datamem: RTL and testbench

Parametrised data memory with memory-mapped IO for the pipelined CPU's MEM stage. It is a word-addressed synchronous RAM plus an IO window at 0xffffff00-0xffffffff. The window holds switches, keys, 7-segment digits and LEDs. New over the previous generation: configurable RAM depth and IO counts, 2-flop input synchronisers, and a sticky key-press event register with read-to-clear.

---
 rtl/pipe_mmio_datamem_if.sv | 18 +
 rtl/pipe_mmio_datamem.sv | 149 ++++++++++++++
 tb/tb_pipe_mmio_datamem.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mmio_datamem_if.sv
//------------------------------------------------------------------------------
// Module : pipe_mmio_datamem_if
// Desc   : MEM-stage data bus between the CPU pipeline and the data memory.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_mmio_datamem_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;

    modport master (output addr, output datain, output we, input dataout);
    modport slave  (input addr, input datain, input we, output dataout);
endinterface

`default_nettype wire

// File: rtl/pipe_mmio_datamem.sv
//------------------------------------------------------------------------------
// Module : pipe_mmio_datamem
// Desc   : Word RAM plus IO window at 0xffffff00 (switches, keys, 7-seg, LEDs,
//          sticky key events). Define MMIO_TIMER_EN to add a timer at 0xffffffa0.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_mmio_datamem #(
    parameter int ADDR_BITS = 5,
    parameter int NUM_HEX   = 6,
    parameter int NUM_LED   = 10,
    parameter int NUM_SW    = 10,
    parameter int NUM_KEY   = 3
) (
    input  wire                    ram_clock,
    input  wire                    resetn,
    pipe_mmio_datamem_if.slave     bus,
    input  wire [NUM_SW-1:0]       sw,
    input  wire [NUM_KEY:1]        key,
    output logic [7*NUM_HEX-1:0]   hex,
    output logic [NUM_LED-1:0]     led
);

    localparam int         c_DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0] c_OFF_SW   = 8'h00;
    localparam logic [7:0] c_OFF_KEY  = 8'h10;
    localparam logic [7:0] c_OFF_LED  = 8'h80;
    localparam logic [7:0] c_OFF_EVT  = 8'h90;
`ifdef MMIO_TIMER_EN
    localparam logic [7:0] c_OFF_TMR  = 8'ha0;
`endif

    logic [31:0]          r_mem [0:c_DEPTH-1];
    logic [31:0]          r_dataout;
    logic [NUM_SW-1:0]    r_sw_s1;
    logic [NUM_SW-1:0]    r_sw_s2;
    logic [NUM_KEY:1]     r_key_s1;
    logic [NUM_KEY:1]     r_key_s2;
    logic [NUM_KEY:1]     r_key_evt;
    logic [NUM_LED-1:0]   r_led;

    logic                 w_io_hit;
    logic                 w_ram_we;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_sel_led;
    logic                 w_sel_evt;
    logic [NUM_KEY:1]     w_key_press;
    logic [NUM_KEY:1]     w_evt_clr;
    logic [NUM_KEY:1]     w_evt_next;
    logic [31:0]          w_rdata;

    assign w_io_hit  = (bus.addr[31:8] == 24'hffffff);
    assign w_ram_we  = bus.we & ~w_io_hit;
    assign w_idx     = bus.addr[ADDR_BITS+1:2];
    assign w_sel_led = w_io_hit && (bus.addr[7:0] == c_OFF_LED);
    assign w_sel_evt = w_io_hit && (bus.addr[7:0] == c_OFF_EVT);

    // A read clears exactly what it returned; a W1C write clears selected bits.
    // A press landing on the same edge is OR-ed in afterwards so it survives.
    assign w_key_press = r_key_s2 & ~r_key_s1;
    assign w_evt_clr   = ({NUM_KEY{w_sel_evt & ~bus.we}} & r_key_evt)
                       | ({NUM_KEY{w_sel_evt &  bus.we}} & bus.datain[NUM_KEY:1]);
    assign w_evt_next  = (r_key_evt & ~w_evt_clr) | w_key_press;

`ifdef MMIO_TIMER_EN
    logic [31:0] r_timer;
    logic        w_sel_tmr;

    assign w_sel_tmr = w_io_hit && (bus.addr[7:0] == c_OFF_TMR);

    always_ff @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (w_sel_tmr && bus.we) begin
            r_timer <= bus.datain;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_io_hit) begin
            w_rdata = r_mem[w_idx];
        end else begin
            case (bus.addr[7:0])
                c_OFF_SW:  w_rdata = 32'(r_sw_s2);
                c_OFF_KEY: w_rdata = 32'({r_key_s2, 1'b1});
                c_OFF_EVT: w_rdata = 32'({r_key_evt, 1'b0});
`ifdef MMIO_TIMER_EN
                c_OFF_TMR: w_rdata = r_timer;
`endif
                default:   w_rdata = '0;
            endcase
        end
    end

    // RAM has no reset; non-blocking update gives old-data on read-during-write.
    always_ff @(posedge ram_clock) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= bus.datain;
        end
    end

    always_ff @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            r_dataout <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_key_s1  <= '1;
            r_key_s2  <= '1;
            r_key_evt <= '0;
            r_led     <= '0;
        end else begin
            r_dataout <= w_rdata;
            r_sw_s1   <= sw;
            r_sw_s2   <= r_sw_s1;
            r_key_s1  <= key;
            r_key_s2  <= r_key_s1;
            r_key_evt <= w_evt_next;
            if (w_sel_led && bus.we) begin
                r_led <= bus.datain[NUM_LED-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
        localparam logic [7:0] c_OFF_HEX = 8'(32 + 16 * gi);
        logic [6:0] r_digit;

        always_ff @(posedge ram_clock or negedge resetn) begin
            if (!resetn) begin
                r_digit <= 7'h7f;
            end else if (w_io_hit && bus.we && (bus.addr[7:0] == c_OFF_HEX)) begin
                r_digit <= bus.datain[6:0];
            end
        end

        assign hex[7*gi +: 7] = r_digit;
    end

    assign led         = r_led;
    assign bus.dataout = r_dataout;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mmio_datamem.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_mmio_datamem
// Desc   : Directed bench for pipe_mmio_datamem with a behavioural reference.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_mmio_datamem;

    localparam int ADDR_BITS = 5;
    localparam int NUM_HEX   = 6;
    localparam int NUM_LED   = 10;
    localparam int NUM_SW    = 10;
    localparam int NUM_KEY   = 3;
    localparam logic [31:0] c_IDLE = 32'hfffffff0;

    logic                  ram_clock;
    logic                  resetn;
    logic [NUM_SW-1:0]     sw;
    logic [NUM_KEY:1]      key;
    logic [7*NUM_HEX-1:0]  hex;
    logic [NUM_LED-1:0]    led;

    pipe_mmio_datamem_if bus ();

    pipe_mmio_datamem #(
        .ADDR_BITS (ADDR_BITS),
        .NUM_HEX   (NUM_HEX),
        .NUM_LED   (NUM_LED),
        .NUM_SW    (NUM_SW),
        .NUM_KEY   (NUM_KEY)
    ) u_dut (
        .ram_clock (ram_clock),
        .resetn    (resetn),
        .bus       (bus),
        .sw        (sw),
        .key       (key),
        .hex       (hex),
        .led       (led)
    );

    initial ram_clock = 1'b0;
    always #5 ram_clock = ~ram_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the RAM is a sparse word map, synchronisers are a
    // two-sample delay line, the IO window is decoded by byte offset.
    logic [31:0]          m_mem [int];
    logic [31:0]          m_dout;
    bit                   m_known;
    logic [NUM_LED-1:0]   m_led;
    logic [7*NUM_HEX-1:0] m_hex;
    logic [NUM_KEY:1]     m_evt, k_old, k_new, m_clr;
    logic [NUM_SW-1:0]    s_old, s_new;
    logic [31:0]          m_timer, m_a, m_rd;
    int                   m_off, m_idx;

    always @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            m_dout = '0; m_known = 1'b1; m_led = '0; m_hex = '1; m_evt = '0;
            k_old = '1; k_new = '1; s_old = '0; s_new = '0; m_timer = '0;
        end else begin
            m_a = bus.addr; m_off = int'(m_a[7:0]); m_rd = '0; m_known = 1'b1; m_clr = '0;
            if (m_a[31:8] != 24'hffffff) begin
                m_idx = int'((m_a >> 2) % (32'd1 << ADDR_BITS));
                if (m_mem.exists(m_idx)) m_rd = m_mem[m_idx];
                else m_known = 1'b0;
                if (bus.we) m_mem[m_idx] = bus.datain;
            end else begin
                if (m_off == 'h00) m_rd = 32'(s_old);
                else if (m_off == 'h10) m_rd = 32'({k_old, 1'b1});
                else if (m_off == 'h90) begin
                    m_rd  = 32'({m_evt, 1'b0});
                    m_clr = bus.we ? bus.datain[NUM_KEY:1] : m_evt;
                end
`ifdef MMIO_TIMER_EN
                else if (m_off == 'ha0) m_rd = m_timer;
`endif
                if (bus.we && m_off == 'h80) m_led = bus.datain[NUM_LED-1:0];
                if (bus.we && m_off >= 32 && m_off < 32 + 16*NUM_HEX && m_off % 16 == 0)
                    m_hex[7*((m_off-32)/16) +: 7] = bus.datain[6:0];
            end
            m_evt = (m_evt & ~m_clr) | (k_old & ~k_new);
            k_old = k_new; k_new = key; s_old = s_new; s_new = sw;
`ifdef MMIO_TIMER_EN
            if (m_a == 32'hffffffa0 && bus.we) m_timer = bus.datain;
            else m_timer = m_timer + 32'd1;
`endif
            m_dout = m_rd;
        end
    end

    always @(negedge ram_clock) begin
        if (resetn === 1'b1) begin
            if (m_known) check("model_dataout", 64'(bus.dataout), 64'(m_dout));
            check("model_led", 64'(led), 64'(m_led));
            check("model_hex", 64'(hex), 64'(m_hex));
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w);
        bus.addr = a; bus.datain = d; bus.we = w;
        @(posedge ram_clock);
        @(negedge ram_clock);
        bus.addr = c_IDLE; bus.datain = '0; bus.we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; sw = '0; key = '1;
        bus.addr = c_IDLE; bus.datain = '0; bus.we = 1'b0;
        repeat (3) @(negedge ram_clock);
        check("rst_dataout", 64'(bus.dataout), 64'h0);
        check("rst_led", 64'(led), 64'h0);
        check("rst_hex", 64'(hex), 64'h3ff_ffff_ffff);
        #2 resetn = 1'b1;
        @(negedge ram_clock);

        op(32'h4, 32'h12345678, 1'b1);
        op(32'h0, 32'hcafef00d, 1'b1);
        op(32'h4, 32'h0, 1'b0);
        check("ram_rd4", 64'(bus.dataout), 64'h12345678);
        op(32'hffffff80, 32'h3ff, 1'b1);
        check("led_wr", 64'(led), 64'h3ff);
        op(32'h0, 32'h0, 1'b0);
        check("ram0_kept", 64'(bus.dataout), 64'hcafef00d);

        sw = 10'h2a5;
        op(32'hffffff00, 32'h0, 1'b0);
        check("sw_edge1", 64'(bus.dataout), 64'h0);
        op(32'hffffff00, 32'h0, 1'b0);
        check("sw_edge2", 64'(bus.dataout), 64'h0);
        op(32'hffffff00, 32'h0, 1'b0);
        check("sw_edge3", 64'(bus.dataout), 64'h2a5);

        key = 3'b101;
        op(32'hffffff10, 32'h0, 1'b0);
        check("key_edge1", 64'(bus.dataout), 64'hf);
        op(32'hffffff10, 32'h0, 1'b0);
        op(32'hffffff10, 32'h0, 1'b0);
        check("key_sync", 64'(bus.dataout), 64'hb);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_key2", 64'(bus.dataout), 64'h4);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_rd_clr", 64'(bus.dataout), 64'h0);

        key = 3'b100;
        op(c_IDLE, 32'h0, 1'b0);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_race_rd", 64'(bus.dataout), 64'h0);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_race_kept", 64'(bus.dataout), 64'h2);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_race_clr", 64'(bus.dataout), 64'h0);

        key = 3'b111;
        repeat (3) op(c_IDLE, 32'h0, 1'b0);
        key = 3'b010;
        repeat (3) op(c_IDLE, 32'h0, 1'b0);
        op(32'hffffff90, 32'h2, 1'b1);
        check("evt_w1c_rd", 64'(bus.dataout), 64'ha);
        op(32'hffffff90, 32'h0, 1'b0);
        check("evt_w1c", 64'(bus.dataout), 64'h8);
        key = 3'b111;

        op(32'hffffff70, 32'h40, 1'b1);
        check("hex5", 64'(hex[41:35]), 64'h40);
        op(32'hffffff04, 32'hdead, 1'b1);
        op(32'h4, 32'h0, 1'b0);
        check("io_no_ram", 64'(bus.dataout), 64'h12345678);
        op(32'hffffff80, 32'h0, 1'b0);
        check("led_rd_zero", 64'(bus.dataout), 64'h0);

`ifdef MMIO_TIMER_EN
        op(32'hffffffa0, 32'hfffffffe, 1'b1);
        repeat (3) op(c_IDLE, 32'h0, 1'b0);
        op(32'hffffffa0, 32'h0, 1'b0);
        check("timer_wrap", 64'(bus.dataout), 64'h1);
`else
        op(32'hffffffa0, 32'h55, 1'b1);
        op(32'hffffffa0, 32'h0, 1'b0);
        check("timer_absent", 64'(bus.dataout), 64'h0);
`endif

        repeat (2) op(c_IDLE, 32'h0, 1'b0);
        bus.addr = 32'hffffff80; bus.datain = 32'h155; bus.we = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_hex", 64'(hex), 64'h3ff_ffff_ffff);
        check("mid_rst_led", 64'(led), 64'h0);
        check("mid_rst_dout", 64'(bus.dataout), 64'h0);
        @(negedge ram_clock);
        check("rst_hold_led", 64'(led), 64'h0);
        #2 resetn = 1'b1;
        op(32'hffffff90, 32'h0, 1'b0);
        check("post_rst_evt", 64'(bus.dataout), 64'h0);
        op(32'h4, 32'h0, 1'b0);
        check("post_rst_ram", 64'(bus.dataout), 64'h12345678);
        op(c_IDLE, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
